// File: rtl/dummy_aip_multimode.sv
// Parametrised dummy AIP core: host-loaded MEMIN is moved to MEMOUT through one of four transforms.
// Optional DUMMY_AIP_DELAY_EN adds a programmable idle gap (WAIT state) after each word.
module dummy_aip_multimode #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          MEM_ADDR_WIDTH = 6,
    parameter logic [31:0] IP_ID          = 32'h00001002
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  en_s,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  write,
    input  logic                  read,
    input  logic                  start,
    input  logic [4:0]            conf_dbus,
    output logic                  int_req
);
    localparam int AW    = MEM_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [4:0] A_MEMIN   = 5'b00000;
    localparam logic [4:0] A_PTR_IN  = 5'b00001;
    localparam logic [4:0] A_MEMOUT  = 5'b00010;
    localparam logic [4:0] A_PTR_OUT = 5'b00011;
    localparam logic [4:0] A_CONF    = 5'b00100;
    localparam logic [4:0] A_STATUS  = 5'b11110;
    localparam logic [4:0] A_ID      = 5'b11111;

    logic [DATA_WIDTH-1:0] memin  [DEPTH];
    logic [DATA_WIDTH-1:0] memout [DEPTH];

    logic [AW-1:0]         ptr_in, ptr_out, rd_idx, wr_idx, wr_addr;
    logic [2:0]            state;
    logic                  done, int_en, rd_vld;
    logic [1:0]            mode;
    logic [7:0]            len;
    logic [DATA_WIDTH-1:0] rd_data, acc, wr_data, conf_rd, status_rd;
    logic [AW:0]           len_eff, rev_idx;
    logic                  busy, host_wr, host_rd, go, wr_en, last_rd, last_wr;
`ifdef DUMMY_AIP_DELAY_EN
    logic [15:0]           delay, dly_cnt;
`endif

    assign busy    = (state != S_IDLE);
    assign host_wr = en_s & write;
    assign host_rd = en_s & read;
    assign go      = en_s & start & ~busy;
    assign wr_en   = en_s & rd_vld;
    assign int_req = done & int_en;

    // LEN of 0 selects the whole memory, so the effective length needs one extra bit
    assign len_eff = (len[AW-1:0] == '0) ? (AW+1)'(DEPTH) : {1'b0, len[AW-1:0]};
    assign last_rd = ({1'b0, rd_idx} == len_eff - 1'b1);
    assign last_wr = ({1'b0, wr_idx} == len_eff - 1'b1);
    assign rev_idx = len_eff - 1'b1 - {1'b0, wr_idx};
    assign wr_addr = (mode == 2'b10) ? rev_idx[AW-1:0] : wr_idx;

    always_comb begin
        wr_data = rd_data;
        case (mode)
            2'b01:   wr_data = ~rd_data;
            2'b11:   wr_data = acc + rd_data;
            default: wr_data = rd_data;
        endcase
    end

    always_comb begin
        conf_rd        = '0;
        conf_rd[1:0]   = mode;
        conf_rd[2]     = int_en;
        conf_rd[15:8]  = len;
        status_rd      = '0;
        status_rd[0]   = done;
        status_rd[1]   = busy;
`ifdef DUMMY_AIP_DELAY_EN
        conf_rd[31:16] = delay;
        status_rd[2]   = (state == S_WAIT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_a) begin
            if (host_wr && conf_dbus == A_MEMIN && !busy) memin[ptr_in] <= data_in;
            if (wr_en) memout[wr_addr] <= wr_data;
        end
    end

    // Transfer engine: everything freezes while en_s is low, including the pending write
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state   <= S_IDLE;
            rd_vld  <= 1'b0;
            rd_idx  <= '0;
            wr_idx  <= '0;
            rd_data <= '0;
            acc     <= '0;
            done    <= 1'b0;
`ifdef DUMMY_AIP_DELAY_EN
            dly_cnt <= '0;
`endif
        end else begin
            if (en_s && state == S_DONE)
                done <= 1'b1;
            else if (go || (host_wr && conf_dbus == A_STATUS && data_in[0]))
                done <= 1'b0;
            if (en_s) begin
                rd_vld <= (state == S_RUN);
                if (state == S_RUN) begin
                    rd_data <= memin[rd_idx];
                    wr_idx  <= rd_idx;
                    rd_idx  <= rd_idx + 1'b1;
                end
                if (rd_vld) acc <= acc + rd_data;
                case (state)
                    S_IDLE: if (go) begin
                        state  <= S_RUN;
                        rd_idx <= '0;
                        acc    <= '0;
                    end
                    S_RUN: begin
`ifdef DUMMY_AIP_DELAY_EN
                        if (delay != '0) begin
                            state   <= S_WAIT;
                            dly_cnt <= delay;
                        end else
`endif
                        if (last_rd) state <= S_FLUSH;
                    end
`ifdef DUMMY_AIP_DELAY_EN
                    S_WAIT: begin
                        dly_cnt <= dly_cnt - 1'b1;
                        if (dly_cnt == 16'd1) state <= last_wr ? S_FLUSH : S_RUN;
                    end
`endif
                    S_FLUSH: state <= S_DONE;
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Host register file and read port
    always_ff @(posedge clk) begin
        if (rst_a) begin
            data_out <= '0;
            ptr_in   <= '0;
            ptr_out  <= '0;
            mode     <= '0;
            int_en   <= 1'b0;
            len      <= '0;
`ifdef DUMMY_AIP_DELAY_EN
            delay    <= '0;
`endif
        end else begin
            if (host_rd) begin
                case (conf_dbus)
                    A_MEMOUT: if (!busy) begin
                        data_out <= memout[ptr_out];
                        ptr_out  <= ptr_out + 1'b1;
                    end
                    A_CONF:   data_out <= conf_rd;
                    A_STATUS: data_out <= status_rd;
                    A_ID:     data_out <= DATA_WIDTH'(IP_ID);
                    default:  data_out <= '0;
                endcase
            end
            if (host_wr) begin
                case (conf_dbus)
                    A_MEMIN:   if (!busy) ptr_in <= ptr_in + 1'b1;
                    A_PTR_IN:  ptr_in  <= data_in[AW-1:0];
                    A_PTR_OUT: ptr_out <= data_in[AW-1:0];
                    A_CONF: if (!busy) begin
                        mode   <= data_in[1:0];
                        int_en <= data_in[2];
                        len    <= data_in[15:8];
`ifdef DUMMY_AIP_DELAY_EN
                        delay  <= data_in[31:16];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dummy_aip_multimode.sv
// Scoreboard bench for dummy_aip_multimode: expected read data is queued at the strobe and
// compared when data_out updates; completion latency is measured against the start edge.
module tb_dummy_aip_multimode;
    logic        clk = 1'b0;
    logic        rst_a = 1'b1, en_s = 1'b1, write = 1'b0, read = 1'b0, start = 1'b0;
    logic [31:0] data_in = '0;
    logic [4:0]  conf_dbus = '0;
    logic [31:0] data_out;
    logic        int_req;

    dummy_aip_multimode dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s), .data_in(data_in), .data_out(data_out),
        .write(write), .read(read), .start(start), .conf_dbus(conf_dbus), .int_req(int_req)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] A_MEMIN = 5'b00000, A_PTR_IN = 5'b00001, A_MEMOUT = 5'b00010;
    localparam logic [4:0] A_PTR_OUT = 5'b00011, A_CONF = 5'b00100, A_STATUS = 5'b11110;
    localparam logic [4:0] A_ID = 5'b11111;

    int          n_tests = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_do = '0;
    logic [31:0] rnd[64];
    logic [31:0] sum;
    logic        rd_pend = 1'b0;
    int          cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Scoreboard: one queued expectation per accepted read strobe
    always @(posedge clk) rd_pend <= read && en_s && !rst_a;
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) check("unexpected_read", data_out, 32'hxxxxxxxx);
            else check("read_data", data_out, exp_q.pop_front());
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write = 1'b1; conf_dbus = a; data_in = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        last_do = exp;
        read = 1'b1; conf_dbus = a;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // c0 = negedges already elapsed since the start edge
    task automatic wait_irq(input int c0, output int c);
        c = c0;
        while (!int_req && c < 1000) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rnd[i] = $urandom;
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 32'h0);
        check("reset_int_req", {31'b0, int_req}, 32'h0);
        rst_a = 1'b0;
        rd(A_ID, 32'h00001002);
        rd(A_STATUS, 32'h0);
        rd(A_CONF, 32'h0);
        wr(5'b01010, 32'h12345678);
        rd(5'b01010, 32'h0);

        // Full-depth copy with interrupt
        wr(A_PTR_IN, 32'h0);
        for (int i = 0; i < 64; i++) wr(A_MEMIN, rnd[i]);
        wr(A_CONF, 32'h0000_0004);
        rd(A_CONF, 32'h0000_0004);
        go();
        wait_irq(1, cyc);
        check("copy64_latency", cyc, 67);
        rd(A_STATUS, 32'h1);
        wr(A_PTR_OUT, 32'h0);
        for (int i = 0; i < 64; i++) rd(A_MEMOUT, rnd[i]);
        check("irq_before_clear", {31'b0, int_req}, 32'h1);
        wr(A_STATUS, 32'h1);
        check("irq_after_clear", {31'b0, int_req}, 32'h0);
        rd(A_STATUS, 32'h0);

        // Running sum, reverse and invert
        wr(A_PTR_IN, 32'h0);
        for (int i = 1; i <= 8; i++) wr(A_MEMIN, i);
        wr(A_CONF, 32'h0000_0807);
        go();
        wait_irq(1, cyc);
        check("sum_latency", cyc, 11);
        wr(A_PTR_OUT, 32'h0);
        sum = 0;
        for (int i = 1; i <= 8; i++) begin
            sum = sum + i;
            rd(A_MEMOUT, sum);
        end
        wr(A_CONF, 32'h0000_0806);
        go();
        wait_irq(1, cyc);
        check("rev_latency", cyc, 11);
        wr(A_PTR_OUT, 32'h0);
        for (int i = 0; i < 8; i++) rd(A_MEMOUT, 8 - i);
        wr(A_PTR_IN, 32'h0);
        wr(A_MEMIN, 32'h0000FFFF);
        wr(A_CONF, 32'h0000_0105);
        go();
        wait_irq(1, cyc);
        wr(A_PTR_OUT, 32'h0);
        rd(A_MEMOUT, 32'hFFFF0000);

        // Running-sum wrap
        wr(A_PTR_IN, 32'h0);
        wr(A_MEMIN, 32'hFFFFFFFF);
        wr(A_MEMIN, 32'hFFFFFFFF);
        wr(A_CONF, 32'h0000_0207);
        go();
        wait_irq(1, cyc);
        check("ovf_latency", cyc, 5);
        wr(A_PTR_OUT, 32'h0);
        rd(A_MEMOUT, 32'hFFFFFFFF);
        rd(A_MEMOUT, 32'hFFFFFFFE);

        // Host activity while busy is ignored
        wr(A_PTR_IN, 32'h0);
        for (int i = 0; i < 8; i++) wr(A_MEMIN, 32'h100 + i);
        wr(A_CONF, 32'h0000_0804);
        go();
        rd(A_STATUS, 32'h2);
        rd(A_MEMOUT, last_do);
        go();
        wr(A_MEMIN, 32'hDEAD);
        wr(A_CONF, 32'h0000_0001);
        wait_irq(6, cyc);
        check("busy_ignore_latency", cyc, 11);
        rd(A_CONF, 32'h0000_0804);
        wr(A_MEMIN, 32'h5555);
        wr(A_CONF, 32'h0000_0A04);
        go();
        wait_irq(1, cyc);
        wr(A_PTR_OUT, 32'h0);
        for (int i = 0; i < 8; i++) rd(A_MEMOUT, 32'h100 + i);
        rd(A_MEMOUT, 32'h5555);
        rd(A_MEMOUT, rnd[9]);

        // en_s low for five cycles mid-run
        wr(A_CONF, 32'h0000_0804);
        go();
        repeat (2) begin @(negedge clk); cyc++; end
        cyc = 3;
        en_s = 1'b0;
        repeat (5) @(negedge clk);
        en_s = 1'b1;
        wait_irq(8, cyc);
        check("en_s_stall_latency", cyc, 16);

`ifdef DUMMY_AIP_DELAY_EN
        wr(A_CONF, 32'h0003_0404);
        rd(A_CONF, 32'h0003_0404);
        go();
        wait_irq(1, cyc);
        check("delay_latency", cyc, 19);
        wr(A_PTR_OUT, 32'h0);
        for (int i = 0; i < 4; i++) rd(A_MEMOUT, 32'h100 + i);
`endif

        // Reset mid-run
        wr(A_CONF, 32'h0000_0004);
        go();
        repeat (10) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        last_do = 32'h0;
        check("rst_mid_int_req", {31'b0, int_req}, 32'h0);
        check("rst_mid_data_out", data_out, 32'h0);
        rd(A_STATUS, 32'h0);
        rd(A_CONF, 32'h0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
